seq_detect_4_6_shift_reg: RTL and testbench
===========================================

Name: seq_detect_4_6_shift_reg

Overview:
Serial-bit pattern detector driven by one shift register per pattern. Every clock it shifts in `new_bit` and compares the stored history against two fixed patterns: a 4-bit pattern (default 1010) and a 6-bit pattern (default 110011). It sits on a serial bit stream and raises a one-cycle flag per match; overlapping matches are all reported.

Parameters:
- PATTERN4, 4'b1010, 4-bit pattern; MSB is the oldest bit received.
- PATTERN6, 6'b110011, 6-bit pattern; MSB is the oldest bit received.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on the rising clk edge.
- new_bit  input  1  serial data; one bit is sampled every rising edge.
- det4  output  1  high while the 4-bit history equals PATTERN4.
- det6  output  1  high while the 6-bit history equals PATTERN6.

Behaviour:
- State is sr4[3:0] and sr6[5:0]; there is no other state unless the Optional Feature is enabled.
- Reset: on a rising edge with rst==0, sr4 and sr6 are cleared to 0. det4 and det6 are 0 from that edge, because both patterns contain 1s.
- Shift: on a rising edge with rst==1:
  - sr4 <= {sr4[2:0], new_bit}
  - sr6 <= {sr6[4:0], new_bit}
  - No enable; a shift happens every cycle.
- Outputs:
  - det4 = (sr4 == PATTERN4); det6 = (sr6 == PATTERN6).
  - Both are pure combinational decodes of the registers; there is no combinational path from new_bit.
- Latency: a flag goes high immediately after the edge that samples the last pattern bit. It stays high for exactly one cycle unless the next edge completes another match.
- Overlap: matches are not consumed.
  - Stream 101010 gives det4 pulses 2 cycles apart.
  - Stream 1100110011 gives det6 pulses 4 cycles apart.
- The two detectors are independent; both may assert in the same cycle.
- Reset mid-stream: partial history is discarded. A match needs the full pattern length of bits after reset is released.
- An X on new_bit during reset has no effect: reset has priority.

Optional Feature:
- Macro: SEQ_DET_FILL_GUARD_EN.
- Defined:
  - Adds a 3-bit saturating fill counter, cleared by reset and incremented per shifted bit, saturating at 6.
  - det4 is gated to 0 until at least 4 bits have been shifted since reset; det6 until at least 6 bits.
  - This prevents matches against reset-filled zeros when a pattern is parameterised to contain leading zeros.
- Undefined: no counter; outputs are the raw compares.
- With the default patterns, behaviour is identical in both builds.

Test Plan:
- Reset check: hold rst=0 for 2 cycles with new_bit=X -> det4=0, det6=0; release rst=1.
- Main stream: after reset release, drive new_bit one bit per cycle, bit 0 first: 0011_0101_1001_1001_1010_1000 (24 bits). Sample outputs just before each edge that samples bit i:
  - det4 = 0000_0001_0000_0000_0000_1010 (high at i=7, 20, 22).
  - det6 = 0000_0000_0000_0100_0100_0000 (high at i=13, 17).
- Overlap 4-bit: stream 1,0,1,0,1,0 -> det4 high after the 4th and the 6th bits; low after the 5th.
- Overlap 6-bit: stream 1,1,0,0,1,1,0,0,1,1 -> det6 high after the 6th and 10th bits only.
- Reset mid-match: stream 1,1,0,0,1, assert rst=0 for 1 cycle, release, then 1 -> det6 stays 0; the subsequent full stream 110011 -> det6 high.
- Both builds: with SEQ_DET_FILL_GUARD_EN defined and PATTERN4=4'b0000, no det4 for the first 3 bits after reset; with the macro undefined, det4=1 immediately after reset.

Source files
------------

// File: rtl/seq_detect_4_6_shift_reg.sv
// seq_detect_4_6_shift_reg: 4-bit/6-bit serial pattern detector; define SEQ_DET_FILL_GUARD_EN to mask flags until enough bits follow reset
module seq_detect_4_6_shift_reg #(
  parameter logic [3:0] PATTERN4 = 4'b1010,
  parameter logic [5:0] PATTERN6 = 6'b110011
) (
  input  logic clk,
  input  logic rst,
  input  logic new_bit,
  output logic det4,
  output logic det6
);
  logic [3:0] sr4;
  logic [5:0] sr6;
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr4 <= '0;
      sr6 <= '0;
    end else begin
      sr4 <= {sr4[2:0], new_bit};
      sr6 <= {sr6[4:0], new_bit};
    end
  end
`ifdef SEQ_DET_FILL_GUARD_EN
  // Zeros loaded by reset must not count as received history.
  logic [2:0] fill;
  always_ff @(posedge clk)
    fill <= !rst ? 3'd0 : (fill == 3'd6 ? fill : fill + 3'd1);
  always_comb begin
    det4 = (sr4 == PATTERN4) && (fill >= 3'd4);
    det6 = (sr6 == PATTERN6) && (fill == 3'd6);
  end
`else
  always_comb begin
    det4 = sr4 == PATTERN4;
    det6 = sr6 == PATTERN6;
  end
`endif
endmodule

// File: tb/tb_seq_detect_4_6_shift_reg.sv
// tb_seq_detect_4_6_shift_reg: directed checks of both detectors, overlap, reset and the fill guard
module tb_seq_detect_4_6_shift_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic new_bit = 1'b0;
  logic det4, det6, det4z, det6z;
  int total = 0;
  int bad = 0;

  seq_detect_4_6_shift_reg dut (
    .clk(clk), .rst(rst), .new_bit(new_bit), .det4(det4), .det6(det6)
  );

  seq_detect_4_6_shift_reg #(.PATTERN4(4'b0000)) dut_z (
    .clk(clk), .rst(rst), .new_bit(new_bit), .det4(det4z), .det6(det6z)
  );

  always #5 clk = ~clk;

  task automatic shift_bit(input logic b);
    new_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    new_bit = 1'bx;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    shift_bit(1); shift_bit(0); shift_bit(1); shift_bit(0);
    total++;
    if (det4 !== 1'b1) begin bad++; $display("FAIL preload_det4: got %b expected 1", det4); end
    rst = 1'b0;
    new_bit = 1'bx;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (det4 !== 1'b0) begin bad++; $display("FAIL reset_det4 cycle %0d: got %b expected 0", c, det4); end
      total++;
      if (det6 !== 1'b0) begin bad++; $display("FAIL reset_det6 cycle %0d: got %b expected 0", c, det6); end
    end
    rst = 1'b1;
  endtask

  task automatic test_main_stream();
    logic [0:23] stream, exp4, exp6;
    stream = 24'b0011_0101_1001_1001_1010_1000;
    exp4   = 24'b0000_0001_0000_0000_0000_1010;
    exp6   = 24'b0000_0000_0000_0100_0100_0000;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      total++;
      if (det4 !== exp4[i]) begin bad++; $display("FAIL main_det4 i=%0d: got %b expected %b", i, det4, exp4[i]); end
      total++;
      if (det6 !== exp6[i]) begin bad++; $display("FAIL main_det6 i=%0d: got %b expected %b", i, det6, exp6[i]); end
      shift_bit(stream[i]);
    end
  endtask

  task automatic test_overlap4();
    logic [0:5] bits, exp4;
    bits = 6'b101010;
    exp4 = 6'b000101;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      shift_bit(bits[i]);
      total++;
      if (det4 !== exp4[i]) begin bad++; $display("FAIL overlap4 bit %0d: got %b expected %b", i + 1, det4, exp4[i]); end
    end
  endtask

  task automatic test_overlap6();
    logic [0:9] bits, exp6;
    bits = 10'b1100110011;
    exp6 = 10'b0000010001;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      shift_bit(bits[i]);
      total++;
      if (det6 !== exp6[i]) begin bad++; $display("FAIL overlap6 bit %0d: got %b expected %b", i + 1, det6, exp6[i]); end
    end
  endtask

  task automatic test_reset_mid_match();
    logic [0:4] pre;
    logic [0:5] full, exp6;
    pre = 5'b11001;
    full = 6'b110011;
    exp6 = 6'b000001;
    do_reset();
    for (int i = 0; i < 5; i++) shift_bit(pre[i]);
    do_reset();
    shift_bit(1);
    total++;
    if (det6 !== 1'b0) begin bad++; $display("FAIL midreset_det6: got %b expected 0", det6); end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      shift_bit(full[i]);
      total++;
      if (det6 !== exp6[i]) begin bad++; $display("FAIL midreset_full bit %0d: got %b expected %b", i + 1, det6, exp6[i]); end
    end
  endtask

  task automatic test_fill_guard();
    logic guard;
`ifdef SEQ_DET_FILL_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    do_reset();
    total++;
    if (det4z !== !guard) begin bad++; $display("FAIL zero_pat_after_reset: got %b expected %b", det4z, !guard); end
    for (int i = 1; i <= 4; i++) begin
      shift_bit(0);
      total++;
      if (det4z !== (!guard || i >= 4)) begin
        bad++;
        $display("FAIL zero_pat_bit %0d: got %b expected %b", i, det4z, (!guard || i >= 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_main_stream();
    test_overlap4();
    test_overlap6();
    test_reset_mid_match();
    test_fill_guard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
